// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern source: FSM state encoding and
// the default pattern.
package seq_pkg;

  localparam int unsigned STATE_W = 2;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_SHIFT = 2'd1;
  localparam state_t S_GAP   = 2'd2;
  localparam state_t S_DONE  = 2'd3;

  localparam int unsigned PAT_11001_W = 5;
  localparam logic [PAT_11001_W-1:0] PAT_11001 = 5'b11001;

endpackage

// File: rtl/seq_bit_index_ctr.sv
// Loadable down-counter with a terminal-count flag. Used as the bit index
// of the pattern being shifted out.
//   clk, rst     : clock, synchronous active-high reset (count -> 0)
//   load         : load load_val (has priority over dec)
//   load_val     : value to load
//   dec          : decrement by one
//   cnt_nxt_c    : combinational next count (value the counter takes at the edge)
//   tc_c         : combinational flag, current count is zero
module seq_bit_index_ctr #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt_nxt_c,
  output logic         tc_c
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: load wins over decrement.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_nxt_c = cnt_d;
  assign tc_c      = (cnt_q == '0);

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends PATTERN MSB-first, one bit per clock,
// as a burst of repeat_cnt frames with optional inter-frame gap or overlap.
//   clk, rst     : clock, synchronous active-high reset
//   start        : burst request, sampled only in IDLE
//   repeat_cnt   : frames per burst (latched on accepted start)
//   gap_len      : idle cycles between frames (latched on accepted start)
//   overlap_en   : share OVL_LEN bits between frames when gap_len==0 (latched)
//   x_out        : serial data bit
//   x_valid      : x_out carries a pattern bit
//   frame_start  : first emitted bit of each frame
//   busy         : burst in progress (SHIFT or GAP)
//   done         : one-cycle end-of-burst pulse
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int unsigned       PAT_W   = 5,
  parameter logic [PAT_W-1:0]  PATTERN = PAT_W'(PAT_11001),
  parameter int unsigned       OVL_LEN = 1,
  parameter int unsigned       CNT_W   = 8,
  parameter int unsigned       GAP_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] repeat_cnt,
  input  logic [GAP_W-1:0] gap_len,
  input  logic             overlap_en,
  output logic             x_out,
  output logic             x_valid,
  output logic             frame_start,
  output logic             busy,
  output logic             done
);

  localparam int unsigned IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] IDX_FULL = IDX_W'(PAT_W - 1);
  localparam logic [IDX_W-1:0] IDX_OVL  = IDX_W'(PAT_W - 1 - OVL_LEN);

  state_t state_q, state_d;

  logic [CNT_W-1:0] frames_q,  frames_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [GAP_W-1:0] gap_len_q, gap_len_d;
  logic             ovl_en_q,  ovl_en_d;

  logic             idx_load;
  logic [IDX_W-1:0] idx_load_val;
  logic             idx_dec;
  logic [IDX_W-1:0] idx_nxt_c;
  logic             idx_tc_c;
  logic             frame_begin_c;
  logic             ovl_active_c;

  logic x_out_q,       x_out_d;
  logic x_valid_q,     x_valid_d;
  logic frame_start_q, frame_start_d;
  logic busy_q,        busy_d;
  logic done_q,        done_d;

  seq_bit_index_ctr #(
    .W (IDX_W)
  ) u_idx (
    .clk       (clk),
    .rst       (rst),
    .load      (idx_load),
    .load_val  (idx_load_val),
    .dec       (idx_dec),
    .cnt_nxt_c (idx_nxt_c),
    .tc_c      (idx_tc_c)
  );

  // Overlap only takes effect for gapless bursts.
  assign ovl_active_c = ovl_en_q && (gap_len_q == '0);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, burst bookkeeping and bit-index control.
  always_comb begin
    state_d       = state_q;
    frames_d      = frames_q;
    gap_cnt_d     = gap_cnt_q;
    gap_len_d     = gap_len_q;
    ovl_en_d      = ovl_en_q;
    idx_load      = 1'b0;
    idx_load_val  = IDX_FULL;
    idx_dec       = 1'b0;
    frame_begin_c = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          frames_d  = repeat_cnt;
          gap_len_d = gap_len;
          ovl_en_d  = overlap_en;
          if (repeat_cnt != '0) begin
            state_d       = S_SHIFT;
            idx_load      = 1'b1;
            frame_begin_c = 1'b1;
          end else begin
            state_d = S_DONE;
          end
        end
      end

      S_SHIFT: begin
        if (idx_tc_c) begin
          // Last bit of the frame is on the wire this cycle.
          frames_d = frames_q - CNT_W'(1);
          if (frames_q == CNT_W'(1)) begin
            state_d = S_DONE;
          end else if (gap_len_q != '0) begin
            state_d   = S_GAP;
            gap_cnt_d = gap_len_q;
          end else begin
            idx_load      = 1'b1;
            idx_load_val  = ovl_active_c ? IDX_OVL : IDX_FULL;
            frame_begin_c = 1'b1;
          end
        end else begin
          idx_dec = 1'b1;
        end
      end

      S_GAP: begin
        // gap_cnt counts the remaining idle cycles including this one.
        if (gap_cnt_q == GAP_W'(1)) begin
          state_d       = S_SHIFT;
          gap_cnt_d     = '0;
          idx_load      = 1'b1;
          frame_begin_c = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state so the outputs can be registered
  // and still line up with the cycle the FSM is in.
  always_comb begin
    x_valid_d     = (state_d == S_SHIFT);
    x_out_d       = x_valid_d & PATTERN[idx_nxt_c];
    frame_start_d = frame_begin_c;
    busy_d        = (state_d == S_SHIFT) || (state_d == S_GAP);
    done_d        = (state_d == S_DONE);
  end

  // Burst bookkeeping registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      frames_q  <= '0;
      gap_cnt_q <= '0;
      gap_len_q <= '0;
      ovl_en_q  <= 1'b0;
    end else begin
      frames_q  <= frames_d;
      gap_cnt_q <= gap_cnt_d;
      gap_len_q <= gap_len_d;
      ovl_en_q  <= ovl_en_d;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_out_q       <= 1'b0;
      x_valid_q     <= 1'b0;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      x_out_q       <= x_out_d;
      x_valid_q     <= x_valid_d;
      frame_start_q <= frame_start_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign x_out       = x_out_q;
  assign x_valid     = x_valid_q;
  assign frame_start = frame_start_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule
